// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: FSM states, ISA classes,
// bus IDs, address-mux codes, control-word field positions and a word builder.
package control_sequencer_pkg;

  localparam int WORD_WIDTH = 20;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_OPERAND,
    ST_EXEC,
    ST_EXEC2,
    ST_HALTED,
    ST_STEPWAIT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_MOV = 3'd1,
    CLS_LDI = 3'd2,
    CLS_ALU = 3'd3,
    CLS_LD  = 3'd4,
    CLS_ST  = 3'd5,
    CLS_JMP = 3'd6,
    CLS_HLT = 3'd7
  } class_t;

  localparam logic [4:0] ID_IR0 = 5'd0;
  localparam logic [4:0] ID_IR1 = 5'd1;
  localparam logic [4:0] ID_A   = 5'd2;
  localparam logic [4:0] ID_MEM = 5'd4;
  localparam logic [4:0] ID_AR0 = 5'd7;
  localparam logic [4:0] ID_AR1 = 5'd8;
  localparam logic [4:0] ID_PC0 = 5'd9;
  localparam logic [4:0] ID_PC1 = 5'd10;
  localparam logic [4:0] ID_SR  = 5'd17;
  localparam logic [4:0] ID_ALU = 5'd18;

  localparam logic [1:0] AMID_PC = 2'd0;
  localparam logic [1:0] AMID_AR = 2'd1;

  localparam int SID_EN_BIT = 0;
  localparam int MID_EN_BIT = 1;
  localparam int PC_INR_BIT = 2;
  localparam int AMID_LSB   = 3;
  localparam int SID_LSB    = 5;
  localparam int MID_LSB    = 10;
  localparam int ALU_LSB    = 15;

  localparam logic [WORD_WIDTH-1:0] IDLE_WORD = '0;

  function automatic logic [WORD_WIDTH-1:0] make_word(
    input logic       sid_en,
    input logic       mid_en,
    input logic       pc_inr,
    input logic [1:0] amid,
    input logic [4:0] sid,
    input logic [4:0] mid,
    input logic [4:0] alu_op
  );
    logic [WORD_WIDTH-1:0] w;
    w                  = IDLE_WORD;
    w[SID_EN_BIT]      = sid_en;
    w[MID_EN_BIT]      = mid_en;
    w[PC_INR_BIT]      = pc_inr;
    w[AMID_LSB +: 2]   = amid;
    w[SID_LSB +: 5]    = sid;
    w[MID_LSB +: 5]    = mid;
    w[ALU_LSB +: 5]    = alu_op;
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM driving the datapath control_bus.
// Optional single-step mode is enabled by defining CONTROL_SEQUENCER_STEP_EN.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int CTRL_WIDTH   = 33,
  parameter int STATUS_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hlt,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic                    step,
`endif
  input  logic [15:0]             instr_data,
  input  logic [STATUS_WIDTH-1:0] status,
  output logic [CTRL_WIDTH-1:0]   control_bus,
  output logic [3:0]              T,
  output logic                    halted
);

  state_t                  state, next_state;
  logic [WORD_WIDTH-1:0]   word;
  logic [3:0]              t_vec;
  logic                    halted_int;
  class_t                  cls;
  logic [4:0]              f;
  logic [4:0]              ir1_id;
  logic [STATUS_WIDTH-1:0] mask;
  logic                    jmp_taken;
  logic                    unused_bits;

  assign cls         = class_t'(instr_data[7:5]);
  assign f           = instr_data[4:0];
  assign ir1_id      = instr_data[12:8];
  assign mask        = instr_data[STATUS_WIDTH-1:0];
  assign jmp_taken   = (mask == '0) || ((status & mask) != '0);
  assign unused_bits = ^instr_data[15:13];

  // Where an instruction goes after its final cycle.
`ifdef CONTROL_SEQUENCER_STEP_EN
  localparam state_t DONE_STATE = ST_STEPWAIT;
  logic step_q;
  logic step_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step && !step_q;
`else
  localparam state_t DONE_STATE = ST_FETCH;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    word       = IDLE_WORD;
    t_vec      = 4'b0000;
    halted_int = 1'b0;
    case (state)
      ST_FETCH: begin
        t_vec = 4'b0001;
        if (!hlt) begin
          word       = make_word(1'b1, 1'b1, 1'b1, AMID_PC, ID_IR0, ID_MEM, 5'd0);
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        t_vec = 4'b0010;
        case (cls)
          CLS_NOP:          next_state = DONE_STATE;
          CLS_MOV, CLS_LDI: next_state = ST_OPERAND;
          CLS_HLT:          next_state = ST_HALTED;
          default:          next_state = ST_EXEC;
        endcase
      end
      ST_OPERAND: begin
        t_vec      = 4'b0100;
        word       = make_word(1'b1, 1'b1, 1'b1, AMID_PC, ID_IR1, ID_MEM, 5'd0);
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        t_vec      = 4'b1000;
        next_state = DONE_STATE;
        case (cls)
          CLS_MOV: word = make_word(1'b1, 1'b1, 1'b0, AMID_PC, f, ir1_id, 5'd0);
          CLS_LDI: word = make_word(1'b1, 1'b1, 1'b0, AMID_PC, f, ID_IR1, 5'd0);
          CLS_ALU: word = make_word(1'b1, 1'b1, 1'b0, AMID_PC, ID_A, ID_ALU, f);
          CLS_LD:  word = make_word(1'b1, 1'b1, 1'b0, AMID_AR, f, ID_MEM, 5'd0);
          CLS_ST:  word = make_word(1'b1, 1'b1, 1'b0, AMID_AR, ID_MEM, f, 5'd0);
          CLS_JMP: begin
            if (jmp_taken) begin
              word       = make_word(1'b1, 1'b1, 1'b0, AMID_PC, ID_PC0, ID_AR0, 5'd0);
              next_state = ST_EXEC2;
            end
          end
          default: word = IDLE_WORD;
        endcase
      end
      ST_EXEC2: begin
        t_vec      = 4'b1000;
        word       = make_word(1'b1, 1'b1, 1'b0, AMID_PC, ID_PC1, ID_AR1, 5'd0);
        next_state = DONE_STATE;
      end
      ST_HALTED: begin
        halted_int = 1'b1;
      end
`ifdef CONTROL_SEQUENCER_STEP_EN
      ST_STEPWAIT: begin
        if (step_rise) next_state = ST_FETCH;
      end
`endif
      default: next_state = ST_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held so an abort takes effect immediately.
  assign control_bus = reset ? CTRL_WIDTH'(word) : '0;
  assign T           = reset ? t_vec : 4'b0000;
  assign halted      = reset ? halted_int : 1'b0;

endmodule
